fifo_ctrl_arb: RTL and testbench

- Round-robin write arbiter and occupancy controller in front of the team's single-clock `fifo` (DATA/ADDR parameterised, depth 2^ADDR).
- Shares the FIFO write port between NREQ producers and gates a single consumer's pops.
- Keeps the authoritative occupancy count, full and empty flags, and sequences a clean flush.
- The FIFO's own 2-bit status is not used; it cannot represent the full depth.

---
 rtl/fifo_ctrl_arb.sv | 86 ++++++++
 tb/tb_fifo_ctrl_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_arb.sv
// fifo_ctrl_arb: round-robin write arbiter, pop gate and occupancy/flush sequencer
// sitting in front of the shared single-clock fifo.
module fifo_ctrl_arb #(
   parameter int DATA = 16,
   parameter int ADDR = 5,
   parameter int NREQ = 4
) (
   input  logic                 clK,
   input  logic                 rsT_N,
   input  logic [NREQ-1:0]      req_WR,
   input  logic [NREQ*DATA-1:0] req_DATA,
   output logic [NREQ-1:0]      req_GNT,
   input  logic                 rd_REQ,
   output logic                 rd_ACK,
   input  logic                 flush_REQ,
   output logic                 flush_BUSY,
   output logic                 fifo_WR,
   output logic [DATA-1:0]      fifo_IN,
   output logic                 fifo_RD,
   output logic                 fifo_RST,
   output logic [ADDR:0]        level,
   output logic                 full,
   output logic                 empty
);
   localparam int PW = $clog2(NREQ);
   localparam logic [ADDR:0] DEPTH = {1'b1, {ADDR{1'b0}}};

   typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] rr, idx, pick;
   logic          hit, run_ok, wr_acc;

   // Walk downward so the last match written is the one nearest the rr pointer.
   always_comb begin
      hit  = 1'b0;
      pick = rr;
      idx  = rr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(rr) + k) % NREQ);
         if (req_WR[idx]) begin
            hit  = 1'b1;
            pick = idx;
         end
      end
   end

   always_comb begin
      state_nx = state;
      state_nx = state == RUN ? (flush_REQ ? FLUSH : RUN) : state == FLUSH ? HOLD : RUN;
   end

   // A pending flush blocks both ports so the fifo never sees a strobe alongside its reset.
   assign run_ok     = state == RUN && !flush_REQ;
   assign wr_acc     = run_ok && !full && hit;
   assign req_GNT    = wr_acc ? NREQ'(1) << pick : '0;
   assign rd_ACK     = run_ok && rd_REQ && !empty;
   assign full       = level == DEPTH;
   assign empty      = level == '0;
   assign flush_BUSY = state != RUN;

   always_ff @(posedge clK or negedge rsT_N) begin
      if (!rsT_N) begin
         state    <= RUN;
         rr       <= '0;
         level    <= '0;
         fifo_WR  <= 1'b0;
         fifo_IN  <= '0;
         fifo_RD  <= 1'b0;
         fifo_RST <= 1'b0;
      end else begin
         state    <= state_nx;
         fifo_WR  <= wr_acc;
         fifo_RD  <= rd_ACK;
         fifo_RST <= state == RUN && flush_REQ;
         if (wr_acc) begin
            fifo_IN <= req_DATA[pick*DATA +: DATA];
            rr      <= pick == PW'(NREQ - 1) ? '0 : pick + 1'b1;
         end
         if (state == FLUSH)
            level <= '0;
         else if (wr_acc != rd_ACK)
            level <= wr_acc ? level + 1'b1 : level - 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// tb_fifo_ctrl_arb: directed and randomized checks of fifo_ctrl_arb against a
// cycle-level reference model (depth 8, four requesters).
module tb_fifo_ctrl_arb;
   localparam int DATA  = 16;
   localparam int ADDR  = 3;
   localparam int NREQ  = 4;
   localparam int DEPTH = 1 << ADDR;

   logic                 clK = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_wr = '0;
   logic [NREQ*DATA-1:0] req_data = '0;
   logic                 rd_req = 1'b0;
   logic                 flush_req = 1'b0;
   logic [NREQ-1:0]      req_gnt;
   logic                 rd_ack, flush_busy, fifo_wr, fifo_rd, fifo_rst, full, empty;
   logic [DATA-1:0]      fifo_in;
   logic [ADDR:0]        level;

   fifo_ctrl_arb #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
      .clK(clK), .rsT_N(rst_n), .req_WR(req_wr), .req_DATA(req_data), .req_GNT(req_gnt),
      .rd_REQ(rd_req), .rd_ACK(rd_ack), .flush_REQ(flush_req), .flush_BUSY(flush_busy),
      .fifo_WR(fifo_wr), .fifo_IN(fifo_in), .fifo_RD(fifo_rd), .fifo_RST(fifo_rst),
      .level(level), .full(full), .empty(empty)
   );

   always #5 clK = ~clK;

   int n_vec = 0;
   int n_err = 0;

   // reference model: phase 0 = accepting, 1 = fifo being reset, 2 = settle
   int              m_phase, m_rr, m_level;
   logic            m_wr, m_rd, m_rst;
   logic [DATA-1:0] m_in;
   logic [NREQ-1:0] e_gnt, a_gnt;
   logic            e_ack, a_ack;

   task automatic m_reset;
      m_phase = 0; m_rr = 0; m_level = 0;
      m_wr = 0; m_rd = 0; m_rst = 0; m_in = '0;
   endtask

   // one clock: sample combinational outputs mid-cycle, advance model at the edge
   task automatic tick;
      int gi;
      @(negedge clK);
      gi = -1;
      if (m_phase == 0 && !flush_req && m_level < DEPTH)
         for (int k = 0; k < NREQ; k++)
            if (gi < 0 && req_wr[(m_rr + k) % NREQ]) gi = (m_rr + k) % NREQ;
      e_gnt = gi >= 0 ? NREQ'(1) << gi : '0;
      e_ack = rd_req && m_level > 0 && m_phase == 0 && !flush_req;
      a_gnt = req_gnt;
      a_ack = rd_ack;
      @(posedge clK);
      m_wr  = gi >= 0;
      m_rd  = e_ack;
      m_rst = m_phase == 0 && flush_req;
      if (gi >= 0) begin
         m_in = req_data[gi*DATA +: DATA];
         m_rr = (gi + 1) % NREQ;
      end
      m_level = m_phase == 1 ? 0 : m_level + (gi >= 0 ? 1 : 0) - (e_ack ? 1 : 0);
      m_phase = m_phase == 0 ? (flush_req ? 1 : 0) : m_phase == 1 ? 2 : 0;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(posedge clK);
      #1 rst_n = 1'b1;
      repeat (2) tick();
      n_vec += 8;
      if (level !== 0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      if (a_gnt !== '0) begin n_err++; $display("FAIL reset_gnt got %b want 0", a_gnt); end
      if (fifo_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b want 0", fifo_wr); end
      if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd got %b want 0", fifo_rd); end
      if (fifo_rst !== 1'b0) begin n_err++; $display("FAIL reset_rst got %b want 0", fifo_rst); end
      if (flush_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", flush_busy); end
   endtask

   task automatic test_round_robin;
      for (int i = 0; i < NREQ; i++) req_data[i*DATA +: DATA] = DATA'(16'hA000 + i * 16'h0111);
      req_wr = '1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec += 4;
         if (a_gnt !== NREQ'(1) << (i % NREQ)) begin n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", i, a_gnt, NREQ'(1) << (i % NREQ)); end
         if (fifo_wr !== 1'b1) begin n_err++; $display("FAIL rr_wr[%0d] got %b want 1", i, fifo_wr); end
         if (fifo_in !== DATA'(16'hA000 + (i % NREQ) * 16'h0111)) begin n_err++; $display("FAIL rr_in[%0d] got %h want %h", i, fifo_in, DATA'(16'hA000 + (i % NREQ) * 16'h0111)); end
         if (level !== (ADDR+1)'(i + 1)) begin n_err++; $display("FAIL rr_level[%0d] got %0d want %0d", i, level, i + 1); end
      end
      n_vec++;
      if (full !== 1'b1) begin n_err++; $display("FAIL rr_full got %b want 1", full); end
   endtask

   task automatic test_full;
      req_wr = 4'b0100;
      tick();
      n_vec += 2;
      if (a_gnt !== '0) begin n_err++; $display("FAIL full_gnt got %b want 0", a_gnt); end
      if (level !== (ADDR+1)'(DEPTH)) begin n_err++; $display("FAIL full_level got %0d want %0d", level, DEPTH); end
      rd_req = 1'b1;
      tick();
      n_vec += 3;
      if (a_ack !== 1'b1) begin n_err++; $display("FAIL full_ack got %b want 1", a_ack); end
      if (a_gnt !== '0) begin n_err++; $display("FAIL full_pop_gnt got %b want 0", a_gnt); end
      if (level !== (ADDR+1)'(DEPTH - 1)) begin n_err++; $display("FAIL full_pop_level got %0d want %0d", level, DEPTH - 1); end
      rd_req = 1'b0;
      tick();
      n_vec += 2;
      if (a_gnt !== 4'b0100) begin n_err++; $display("FAIL full_resume_gnt got %b want 0100", a_gnt); end
      if (level !== (ADDR+1)'(DEPTH)) begin n_err++; $display("FAIL full_resume_level got %0d want %0d", level, DEPTH); end
   endtask

   task automatic test_simultaneous;
      req_wr = '0;
      rd_req = 1'b1;
      repeat (DEPTH - 2) tick();
      n_vec++;
      if (level !== 2) begin n_err++; $display("FAIL sim_drain_level got %0d want 2", level); end
      req_wr = 4'b0010;
      req_data[1*DATA +: DATA] = 16'h5A5A;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec += 5;
         if (a_gnt !== 4'b0010) begin n_err++; $display("FAIL sim_gnt[%0d] got %b want 0010", i, a_gnt); end
         if (a_ack !== 1'b1) begin n_err++; $display("FAIL sim_ack[%0d] got %b want 1", i, a_ack); end
         if (level !== 2) begin n_err++; $display("FAIL sim_level[%0d] got %0d want 2", i, level); end
         if (fifo_wr !== 1'b1 || fifo_in !== 16'h5A5A) begin n_err++; $display("FAIL sim_wr[%0d] got %b/%h want 1/5a5a", i, fifo_wr, fifo_in); end
         if (fifo_rd !== 1'b1) begin n_err++; $display("FAIL sim_rd[%0d] got %b want 1", i, fifo_rd); end
      end
      req_wr = '0;
      rd_req = 1'b0;
      tick();
      n_vec++;
      if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin n_err++; $display("FAIL sim_idle got wr=%b rd=%b want 0/0", fifo_wr, fifo_rd); end
   endtask

   task automatic test_flush;
      req_wr = '1;
      repeat (3) tick();
      n_vec++;
      if (level !== 5) begin n_err++; $display("FAIL flush_pre_level got %0d want 5", level); end
      rd_req = 1'b1;
      flush_req = 1'b1;
      tick();
      n_vec += 5;
      if (a_gnt !== '0) begin n_err++; $display("FAIL flush_req_gnt got %b want 0", a_gnt); end
      if (a_ack !== 1'b0) begin n_err++; $display("FAIL flush_req_ack got %b want 0", a_ack); end
      if (fifo_rst !== 1'b1) begin n_err++; $display("FAIL flush_rst got %b want 1", fifo_rst); end
      if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin n_err++; $display("FAIL flush_strobes got wr=%b rd=%b want 0/0", fifo_wr, fifo_rd); end
      if (flush_busy !== 1'b1) begin n_err++; $display("FAIL flush_busy got %b want 1", flush_busy); end
      flush_req = 1'b0;
      tick();
      n_vec += 4;
      if (a_gnt !== '0 || a_ack !== 1'b0) begin n_err++; $display("FAIL flush_stage_ports got gnt=%b ack=%b want 0/0", a_gnt, a_ack); end
      if (fifo_rst !== 1'b0) begin n_err++; $display("FAIL hold_rst got %b want 0", fifo_rst); end
      if (level !== 0 || empty !== 1'b1) begin n_err++; $display("FAIL hold_level got %0d/%b want 0/1", level, empty); end
      if (flush_busy !== 1'b1) begin n_err++; $display("FAIL hold_busy got %b want 1", flush_busy); end
      tick();
      n_vec += 2;
      if (a_gnt !== '0 || a_ack !== 1'b0) begin n_err++; $display("FAIL hold_ports got gnt=%b ack=%b want 0/0", a_gnt, a_ack); end
      if (flush_busy !== 1'b0) begin n_err++; $display("FAIL run_busy got %b want 0", flush_busy); end
      req_wr = '0;
      tick();
      n_vec++;
      if (a_ack !== 1'b0) begin n_err++; $display("FAIL empty_pop got %b want 0", a_ack); end
      rd_req = 1'b0;
      req_wr = '1;
      tick();
      n_vec += 2;
      if (a_gnt !== 4'b0010) begin n_err++; $display("FAIL flush_resume_gnt got %b want 0010", a_gnt); end
      if (level !== 1) begin n_err++; $display("FAIL flush_resume_level got %0d want 1", level); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         req_wr    = NREQ'($urandom);
         req_data  = {$urandom, $urandom};
         rd_req    = $urandom_range(0, 99) < 45;
         flush_req = (flush_req && $urandom_range(0, 1) == 1) || $urandom_range(0, 39) == 0;
         tick();
         n_vec += 10;
         if (a_gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b want %b", i, a_gnt, e_gnt); end
         if (a_ack !== e_ack) begin n_err++; $display("FAIL rnd_ack[%0d] got %b want %b", i, a_ack, e_ack); end
         if (fifo_wr !== m_wr) begin n_err++; $display("FAIL rnd_wr[%0d] got %b want %b", i, fifo_wr, m_wr); end
         if (fifo_in !== m_in) begin n_err++; $display("FAIL rnd_in[%0d] got %h want %h", i, fifo_in, m_in); end
         if (fifo_rd !== m_rd) begin n_err++; $display("FAIL rnd_rd[%0d] got %b want %b", i, fifo_rd, m_rd); end
         if (fifo_rst !== m_rst) begin n_err++; $display("FAIL rnd_rst[%0d] got %b want %b", i, fifo_rst, m_rst); end
         if (level !== (ADDR+1)'(m_level)) begin n_err++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, level, m_level); end
         if (full !== (m_level == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d] got %b want %b", i, full, m_level == DEPTH); end
         if (empty !== (m_level == 0)) begin n_err++; $display("FAIL rnd_empty[%0d] got %b want %b", i, empty, m_level == 0); end
         if (flush_busy !== (m_phase != 0)) begin n_err++; $display("FAIL rnd_busy[%0d] got %b want %b", i, flush_busy, m_phase != 0); end
      end
      flush_req = 1'b0;
      rd_req    = 1'b0;
      req_wr    = '0;
   endtask

   task automatic test_async_reset;
      repeat (3) tick();
      req_wr = '1;
      tick();
      n_vec++;
      if (fifo_wr !== m_wr) begin n_err++; $display("FAIL async_pre_wr got %b want %b", fifo_wr, m_wr); end
      #2 rst_n = 1'b0;
      req_wr = '0;
      m_reset();
      #1;
      n_vec += 4;
      if (fifo_wr !== 1'b0) begin n_err++; $display("FAIL async_wr got %b want 0", fifo_wr); end
      if (level !== 0 || empty !== 1'b1) begin n_err++; $display("FAIL async_level got %0d/%b want 0/1", level, empty); end
      if (flush_busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %b want 0", flush_busy); end
      if (fifo_rst !== 1'b0 || fifo_rd !== 1'b0) begin n_err++; $display("FAIL async_strobes got rst=%b rd=%b want 0/0", fifo_rst, fifo_rd); end
      @(posedge clK);
      #1 rst_n = 1'b1;
      req_wr = '1;
      tick();
      n_vec += 2;
      if (a_gnt !== 4'b0001) begin n_err++; $display("FAIL async_rr got %b want 0001", a_gnt); end
      if (level !== 1) begin n_err++; $display("FAIL async_post_level got %0d want 1", level); end
      req_wr = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_full();
      test_simultaneous();
      test_flush();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
